// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the word-organised data memory.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int BE_W = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Byte lanes touched by an access of the given size starting at lane.
    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [1:0] lane);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

    // Natural alignment; the reserved size code never counts as aligned.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Right-aligned store data copied into every lane so the byte enables
    // alone decide which bytes land in the word.
    function automatic logic [31:0] replicate(input logic [1:0]  size,
                                              input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        case (size)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_ctrl_if.sv
// Request/response bundle between the load/store stage and the data memory.
// Latency: none (wires only).
// Backpressure: req_ready from the memory side qualifies req_valid.
interface dm_lane_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       write_data;
    logic              rsp_valid;
    logic [31:0]       read_data;
    logic              misaligned;
    logic              init_busy;

    // Load/store stage side.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, addr, write_data,
        input  req_ready, rsp_valid, read_data, misaligned, init_busy
    );

    // Memory side.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, addr, write_data,
        output req_ready, rsp_valid, read_data, misaligned, init_busy
    );
endinterface

// File: rtl/dm_load_align.sv
// Picks the addressed byte/half out of a 32-bit word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none; shared with the fetch-side byte loader.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension; word loads ignore the unsigned flag.
    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dm_lane_ctrl.sv
// Byte/half/word data memory with alignment check and post-reset clear sweep.
// Latency: 1 cycle accept-to-response; sweep holds req_ready low DEPTH cycles.
// Backpressure: req_ready low only during the sweep; full throughput after.
// Optional: DM_RANGE_CHECK_EN rejects addresses with bits set above the index.
module dm_lane_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    dm_lane_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    // Storage has no reset; the sweep is what zeroes it.
    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;

    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              upper_nz;
    logic              range_err;
    logic              req_err;
    logic              do_store;
    logic [BE_W-1:0]   be;
    logic [31:0]       wdat;
    logic [31:0]       load_word;
    logic [31:0]       load_data;

    assign accept   = bus.req_valid & ready_q;
    assign idx      = bus.addr[IDX_W+1:2];
    assign lane     = bus.addr[1:0];
    assign upper_nz = |(bus.addr >> (IDX_W + 2));

`ifdef DM_RANGE_CHECK_EN
    assign range_err = upper_nz;
`else
    // Upper bits alias onto the array, so they never cause a rejection.
    logic unused_upper_nz;
    assign unused_upper_nz = upper_nz;
    assign range_err       = 1'b0;
`endif

    assign req_err   = ~is_aligned(bus.req_size, lane) | range_err;
    assign do_store  = accept & bus.req_write & ~req_err;
    assign be        = byte_enable(bus.req_size, lane);
    assign wdat      = replicate(bus.req_size, bus.write_data);
    assign load_word = mem[idx];

    dm_load_align u_align (
        .word_i     (load_word),
        .lane_i     (lane),
        .size_i     (bus.req_size),
        .unsigned_i (bus.req_unsigned),
        .data_o     (load_data)
    );

    // Array write: zero one word per cycle while sweeping, else byte-masked store.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end
    end

    // Next-state and next-response decode; response fields fall to 0 when idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        rsp_vld_d = accept;
        mis_d     = accept & req_err;
        rdata_d   = (accept & ~bus.req_write & ~req_err) ? load_data : 32'd0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control state and registered outputs; reset restarts the sweep.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            rsp_vld_q <= 1'b0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
            mis_q     <= mis_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.init_busy  = busy_q;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.read_data  = rdata_q;
    assign bus.misaligned = mis_q;

endmodule

// File: doc/dm_lane_ctrl.md
Name: dm_lane_ctrl

Overview:
- Word-organised data memory with byte/halfword/word access, sign/zero-extended loads and alignment checking.
- Single valid/ready request port with 1-cycle registered response.
- Self-clears its array after reset with a sequential sweep.
- Sits between the load/store stage and storage; next-generation data memory for the single-cycle/multicycle cores.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, >= 2.
- ADDR_W, 32, byte-address width; must be >= log2(DEPTH)+2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend.
- addr  in  ADDR_W  byte address.
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- read_data  out  32  extended load result; 0 for stores and errors.
- misaligned  out  1  qualifies rsp_valid: request rejected.
- init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, read_data=0, misaligned=0, init_busy=1, state=INIT, sweep counter=0.
- Reset is asynchronous: it aborts any operation and restarts the sweep.
- The array itself has no reset; it is cleared only by the sweep.
- States:
  - INIT: write 0 to word[cnt] each cycle, cnt 0..DEPTH-1, req_ready=0. After the cnt=DEPTH-1 write, go to RUN and drop init_busy. The first req_ready=1 is DEPTH cycles after reset deassertion.
  - RUN: req_ready=1 every cycle; a new request may be accepted every cycle (full throughput).
- Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
- Alignment:
  - Byte: always aligned.
  - Half: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
  - Size 11 is treated as misaligned.
- Store (aligned):
  - Byte enables: byte 0001<<lane; half 0011<<lane; word 1111.
  - Data replicated across lanes; only enabled bytes change, written at the accept edge.
  - Next cycle: rsp_valid=1, read_data=0, misaligned=0.
- Load (aligned):
  - Array read at the accept edge; selected lane shifted to bit 0 and extended per req_unsigned.
  - Word loads ignore req_unsigned.
  - Registered result: rsp_valid=1 the cycle after acceptance.
- Misaligned request (load or store):
  - No array write.
  - Next cycle: rsp_valid=1, misaligned=1, read_data=0.
- Load from the same word as a store accepted the previous cycle returns the post-store value (write-then-read ordering).
- Upper address bits above the index range are ignored; addresses wrap modulo DEPTH*4.
- With no accepted request: rsp_valid=0, and read_data/misaligned drop to 0.

Optional Feature:
- Macro: DM_RANGE_CHECK_EN.
- Defined: an access with any nonzero addr bit above log2(DEPTH)+1 is rejected like a misaligned one (no write, rsp_valid with misaligned=1, read_data=0).
- Undefined: upper bits ignored, wrap-around as above.

Decomposition:
- Package dm_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State enum {ST_INIT, ST_RUN}.
  - Byte-enable width constant BE_W=4.
- Sub-module dm_load_align: combinational lane select plus sign/zero extension, taking word, lane, size and unsigned flag. It is reused by the fetch-side byte loader.

Test Plan:
- Reset release, then read every word -> req_ready rises exactly 64 cycles after release (DEPTH=64); all loads return 0.
- Store word 0xDEADBEEF at 0x10; lb 0x13 signed -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF.
- Store byte 0x5A at 0x11 over 0xDEADBEEF -> lw 0x10 returns 0xDEAD5AEF.
- Misaligned cases: lw 0x12, sh 0x21, size 11 -> each gets rsp_valid with misaligned=1, read_data=0; memory unchanged.
- Back-to-back sw 0x40=0x1234, lw 0x40 on consecutive cycles -> responses on consecutive cycles, second returns 0x00001234.
- Assert reset mid-sweep (cycle 20) and mid-store -> outputs return to reset values immediately; full 64-cycle sweep restarts.
- Range-check macro: with DM_RANGE_CHECK_EN, lw 0x100 -> misaligned=1; without it, lw 0x100 aliases word 0.
